// File: rtl/number_display_if.sv
// Bundle of the number_display pins: the value to show and the blank control,
// plus the multiplexed 7-segment pins and the conversion status.
//   number : unsigned value to display (master -> slave)
//   blank  : 1 turns every anode off (master -> slave)
//   seg    : segments {g,f,e,d,c,b,a}, active-low (slave -> master)
//   dp     : decimal point, active-low (slave -> master)
//   an     : anode enables, active-low, an[0] = least significant digit (slave -> master)
//   busy   : binary-to-BCD conversion in progress (slave -> master)
interface number_display_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 4
);
  logic [WIDTH-1:0]  number;
  logic              blank;
  logic [6:0]        seg;
  logic              dp;
  logic [DIGITS-1:0] an;
  logic              busy;

  modport master (output number, blank, input seg, dp, an, busy);
  modport slave  (input number, blank, output seg, dp, an, busy);
endinterface

// File: rtl/number_display.sv
// Multiplexed common-anode 7-segment driver for an unsigned binary number.
// A new input value is converted to BCD with shift-add-3 (one bit per cycle),
// latched into digit registers, then scanned digit by digit with leading-zero
// suppression and a dash pattern when the value does not fit in DIGITS digits.
//   clk   : system clock, posedge
//   reset : asynchronous, active-high
//   bus   : number_display_if slave (number, blank in; seg, dp, an, busy out)
//
// state | meaning
// IDLE  | waiting for number to differ from the last converted value
// SHIFT | shift-add-3 steps, bit counter runs down to zero
// LATCH | copy BCD result into the digit registers
module number_display #(
  parameter int WIDTH        = 8,
  parameter int DIGITS       = 4,
  parameter int REFRESH_BITS = 16
) (
  input  logic              clk,
  input  logic              reset,
  number_display_if.slave   bus
);

  // ceil(WIDTH*log10(2)) + 1 nibbles, never fewer than the displayed digits
  function automatic int calc_nibbles(input int w, input int d);
    int n;
    n = (w * 30103 + 99999) / 100000 + 1;
    return (n < d) ? d : n;
  endfunction

  localparam int NIB   = calc_nibbles(WIDTH, DIGITS);
  localparam int BCD_W = NIB * 4;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0: seg_code = 7'h40;
      4'd1: seg_code = 7'h79;
      4'd2: seg_code = 7'h24;
      4'd3: seg_code = 7'h30;
      4'd4: seg_code = 7'h19;
      4'd5: seg_code = 7'h12;
      4'd6: seg_code = 7'h02;
      4'd7: seg_code = 7'h78;
      4'd8: seg_code = 7'h00;
      4'd9: seg_code = 7'h10;
      default: seg_code = 7'h7F;
    endcase
  endfunction

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    bin_q, bin_d;
  logic [WIDTH-1:0]    last_q, last_d;
  logic [BCD_W-1:0]    bcd_q, bcd_d, bcd_adj;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DIGITS*4-1:0] dig_q, dig_d;
  logic                ovf_q, ovf_d, bcd_ovf;
  logic                changed;

  logic [REFRESH_BITS-1:0] pre_q;
  logic [IDX_W-1:0]        idx_q;
  logic [6:0]              seg_q, seg_d;
  logic [DIGITS-1:0]       an_q, an_d;
  logic [3:0]              cur_dig;
  logic                    upper_zero;

  assign changed = (bus.number != last_q);

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      bin_q   <= '0;
      last_q  <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      dig_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      last_q  <= last_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      dig_q   <= dig_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next state. SHIFT spends one extra cycle at count zero before LATCH.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (changed) state_d = SHIFT;
      SHIFT:   if (cnt_q == '0) state_d = LATCH;
      LATCH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NIB; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
    end
  end

  always_comb begin
    bcd_ovf = 1'b0;
    for (int i = DIGITS; i < NIB; i++) begin
      if (bcd_q[i*4 +: 4] != 4'd0) bcd_ovf = 1'b1;
    end
  end

  // Datapath and status outputs
  always_comb begin
    bin_d    = bin_q;
    last_d   = last_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    dig_d    = dig_q;
    ovf_d    = ovf_q;
    bus.busy = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (changed) begin
          bin_d  = bus.number;
          last_d = bus.number;
          bcd_d  = '0;
          cnt_d  = CNT_W'(WIDTH);
        end
      end
      SHIFT: begin
        if (cnt_q != '0) begin
          {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
          cnt_d          = cnt_q - 1'b1;
        end
      end
      LATCH: begin
        // A result made stale by an input change is dropped; IDLE restarts
        // with the new value so intermediate values never reach the display.
        if (!changed) begin
          dig_d = bcd_q[DIGITS*4-1:0];
          ovf_d = bcd_ovf;
        end
      end
      default: ;
    endcase
  end

  // Digit currently addressed and whether it and everything above is zero
  always_comb begin
    cur_dig    = dig_q[idx_q*4 +: 4];
    upper_zero = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (k >= int'(idx_q) && dig_q[k*4 +: 4] != 4'd0) upper_zero = 1'b0;
    end
  end

  always_comb begin
    if (bus.blank) begin
      seg_d = seg_q;
      an_d  = '1;
    end else begin
      an_d = ~(DIGITS'(1) << idx_q);
      if (ovf_q)                          seg_d = 7'h3F;
      else if (idx_q != '0 && upper_zero) seg_d = 7'h7F;
      else                                seg_d = seg_code(cur_dig);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_q <= '0;
      idx_q <= '0;
      seg_q <= 7'h7F;
      an_q  <= '1;
    end else begin
      pre_q <= pre_q + 1'b1;
      if (pre_q == '1) begin
        idx_q <= (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
      end
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign bus.seg = seg_q;
  assign bus.an  = an_q;
  assign bus.dp  = 1'b1;

endmodule

// File: tb/tb_number_display.sv
// Directed bench for number_display: 8-bit/4-digit instance with a 4-cycle
// scan slot, plus a 16-bit instance for the overflow dash pattern.
module tb_number_display;

  logic clk = 1'b0;
  logic reset;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  number_display_if #(.WIDTH(8),  .DIGITS(4)) bus  ();
  number_display_if #(.WIDTH(16), .DIGITS(4)) bus2 ();

  number_display #(.WIDTH(8), .DIGITS(4), .REFRESH_BITS(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  number_display #(.WIDTH(16), .DIGITS(4), .REFRESH_BITS(2)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Watch 20 cycles: each anode must carry its expected segment code and
  // anodes must step E -> D -> B -> 7 -> E.
  task automatic check_scan(input logic [6:0] e0, input logic [6:0] e1,
                            input logic [6:0] e2, input logic [6:0] e3,
                            input string tag);
    logic [3:0] prev_an;
    logic [6:0] exp_seg;
    prev_an = 4'hF;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      case (bus.an)
        4'hE:    exp_seg = e0;
        4'hD:    exp_seg = e1;
        4'hB:    exp_seg = e2;
        4'h7:    exp_seg = e3;
        default: exp_seg = 7'hxx;
      endcase
      chk({25'd0, bus.seg}, {25'd0, exp_seg}, {tag, "_seg"});
      if (prev_an != 4'hF && bus.an != prev_an)
        chk({28'd0, bus.an}, {28'd0, prev_an[2:0], prev_an[3]}, {tag, "_order"});
      prev_an = bus.an;
    end
  endtask

  task automatic wait_conversion(input string tag);
    int cnt;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.busy) cnt++;
      else if (cnt != 0) break;
    end
    chk(cnt, 10, {tag, "_busy_cycles"});
  endtask

  initial begin
    logic [3:0] exp_an;
    logic       ok;

    reset        = 1'b1;
    bus.number   = 8'd0;
    bus.blank    = 1'b0;
    bus2.number  = 16'd12345;
    bus2.blank   = 1'b0;

    repeat (3) @(negedge clk);
    chk({25'd0, bus.seg}, 32'h7F, "rst_seg");
    chk({28'd0, bus.an},  32'hF,  "rst_an");
    chk({31'd0, bus.busy}, 32'd0, "rst_busy");
    chk({31'd0, bus.dp},   32'd1, "rst_dp");

    // After release: "0" on digit 0, others blank, anodes E,D,B,7 every 4 clk
    reset = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      exp_an = ~(4'b0001 << ((k - 1) / 4));
      chk({28'd0, bus.an}, {28'd0, exp_an}, "zero_an");
      chk({25'd0, bus.seg}, (k <= 4) ? 32'h40 : 32'h7F, "zero_seg");
      chk({31'd0, bus.busy}, 32'd0, "zero_busy");
    end

    bus.number = 8'd123;
    wait_conversion("n123");
    check_scan(7'h30, 7'h24, 7'h79, 7'h7F, "n123");

    bus.number = 8'd255;
    wait_conversion("n255");
    check_scan(7'h12, 7'h12, 7'h24, 7'h7F, "n255");

    // 5, 9, 17 on consecutive cycles; a latched 5 or 9 would blank digit 1
    // or put a 9 on digit 0
    bus.number = 8'd5;
    @(negedge clk);
    bus.number = 8'd9;
    @(negedge clk);
    bus.number = 8'd17;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      ok = !((bus.an == 4'hD && bus.seg == 7'h7F) || (bus.an == 4'hE && bus.seg == 7'h10));
      chk({31'd0, ok}, 32'd1, "no_stale_latch");
    end
    chk({31'd0, bus.busy}, 32'd0, "n17_idle");
    check_scan(7'h78, 7'h79, 7'h7F, 7'h7F, "n17");

    bus.blank = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk({28'd0, bus.an}, 32'hF, "blank_an");
    end
    bus.blank = 1'b0;
    @(negedge clk);
    check_scan(7'h78, 7'h79, 7'h7F, 7'h7F, "unblank");

    // Reset in the middle of a conversion
    bus.number = 8'd200;
    repeat (3) @(negedge clk);
    chk({31'd0, bus.busy}, 32'd1, "pre_reset_busy");
    reset = 1'b1;
    #1;
    chk({25'd0, bus.seg}, 32'h7F, "midrst_seg");
    chk({28'd0, bus.an},  32'hF,  "midrst_an");
    chk({31'd0, bus.busy}, 32'd0, "midrst_busy");
    chk({31'd0, bus.dp},   32'd1, "midrst_dp");
    @(negedge clk);
    reset = 1'b0;
    wait_conversion("n200");
    check_scan(7'h40, 7'h40, 7'h24, 7'h7F, "n200");

    // 16-bit instance: 12345 needs five digits, so every digit shows a dash
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk({25'd0, bus2.seg}, 32'h3F, "ovf_seg");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
